// File: rtl/dsp48a1_mac_sequencer.sv
// Sequencer that runs a length-N multiply-accumulate job on one DSP48A1 slice.
// Optional overflow tracking is enabled by defining DSP48A1_SEQ_OVF_EN.
module dsp48a1_mac_sequencer #(
    parameter int LEN_W = 8,
    parameter int MREG  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [17:0]      s_a,
    input  logic [17:0]      s_b,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_cea,
    output logic             dsp_ceb,
    output logic             dsp_cem,
    output logic             dsp_cep,
    output logic             dsp_rstp,
    input  logic [47:0]      dsp_p,
    input  logic             dsp_carryout,
    output logic [47:0]      result,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_cnt;
    logic [47:0]        r_result;
    logic               r_ovf;

    logic               w_accept;
    logic               w_cem;
    logic               w_cep;
    logic               w_v_empty;
    logic               w_ovf_job;

    assign w_accept   = s_valid && (r_state == S_FEED);

    assign dsp_a      = s_a;
    assign dsp_b      = s_b;
    assign dsp_opmode = 8'h09;
    assign dsp_cea    = w_accept;
    assign dsp_ceb    = w_accept;
    assign dsp_cem    = w_cem;
    assign dsp_cep    = w_cep;
    assign dsp_rstp   = (r_state == S_CLEAR);
    assign busy       = (r_state != S_IDLE);
    assign s_ready    = (r_state == S_FEED);
    assign done       = (r_state == S_DONE);
    assign result     = r_result;
    assign ovf        = r_ovf;

    // Valid bits follow each accepted pair through the slice so only real products reach P.
    generate
        if (MREG != 0) begin : g_mreg
            logic [1:0] r_v;
            // Two-stage tracker: M stage then P stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 2'b00;
                end else begin
                    r_v <= {r_v[0], w_accept};
                end
            end
            assign w_cem     = r_v[0];
            assign w_cep     = r_v[1];
            assign w_v_empty = (r_v == 2'b00);
        end else begin : g_nomreg
            logic r_v;
            // Single-stage tracker: product goes straight to P.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                end else begin
                    r_v <= w_accept;
                end
            end
            assign w_cem     = 1'b0;
            assign w_cep     = r_v;
            assign w_v_empty = ~r_v;
        end
    endgenerate

`ifdef DSP48A1_SEQ_OVF_EN
    logic r_ovf_flag;
    // Sticky carry-out capture over the P updates of the current job.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_flag <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_ovf_flag <= 1'b0;
        end else if (w_cep && dsp_carryout) begin
            r_ovf_flag <= 1'b1;
        end else begin
            r_ovf_flag <= r_ovf_flag;
        end
    end
    assign w_ovf_job = r_ovf_flag;
`else
    logic w_unused_carryout;
    assign w_unused_carryout = dsp_carryout;
    assign w_ovf_job         = 1'b0;
`endif

    // Job FSM; result and ovf are captured on entry to DONE so they are valid with done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= 48'd0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_cnt   <= len;
                            r_state <= S_CLEAR;
                        end else begin
                            r_result <= 48'd0;
                            r_ovf    <= 1'b0;
                            r_state  <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    r_state <= S_FEED;
                end
                S_FEED: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_FEED;
                        end
                    end else begin
                        r_state <= S_FEED;
                    end
                end
                S_DRAIN: begin
                    if (w_v_empty) begin
                        r_result <= dsp_p;
                        r_ovf    <= w_ovf_job;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: one MREG=1 and one MREG=0 instance, each with a behavioural slice.
// Overflow expectations depend on DSP48A1_SEQ_OVF_EN.
module tb_dsp48a1_mac_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        carry_en = 1'b0;
    logic        t_start = 1'b0;
    logic [7:0]  t_len = 8'd0;
    logic        t_valid = 1'b0;
    logic [17:0] t_a = 18'd0;
    logic [17:0] t_b = 18'd0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc_n = 0;
    int tot_cea = 0, tot_cem = 0, tot_cep = 0, tot_rstp = 0;
    int pa[8];
    int pb[8];
    logic [47:0] q_res[$];
    logic        q_ovf[$];

    logic start1, valid1, busy1, ready1, cea1, ceb1, cem1, cep1, rstp1, carry1, done1, ovf1;
    logic start0, valid0, busy0, ready0, cea0, ceb0, cem0, cep0, rstp0, carry0, done0, ovf0;
    logic [17:0] da1, db1, da0, db0;
    logic [7:0]  op1, op0;
    logic [47:0] p1, p0, res1, res0;

    assign start1 = t_start & ~sel;
    assign valid1 = t_valid & ~sel;
    assign start0 = t_start & sel;
    assign valid0 = t_valid & sel;

    dsp48a1_mac_sequencer #(.LEN_W(8), .MREG(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .len(t_len), .busy(busy1),
        .s_valid(valid1), .s_ready(ready1), .s_a(t_a), .s_b(t_b),
        .dsp_a(da1), .dsp_b(db1), .dsp_opmode(op1), .dsp_cea(cea1), .dsp_ceb(ceb1),
        .dsp_cem(cem1), .dsp_cep(cep1), .dsp_rstp(rstp1), .dsp_p(p1),
        .dsp_carryout(carry1), .result(res1), .done(done1), .ovf(ovf1)
    );

    dsp48a1_mac_sequencer #(.LEN_W(8), .MREG(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .len(t_len), .busy(busy0),
        .s_valid(valid0), .s_ready(ready0), .s_a(t_a), .s_b(t_b),
        .dsp_a(da0), .dsp_b(db0), .dsp_opmode(op0), .dsp_cea(cea0), .dsp_ceb(ceb0),
        .dsp_cem(cem0), .dsp_cep(cep0), .dsp_rstp(rstp0), .dsp_p(p0),
        .dsp_carryout(carry0), .result(res0), .done(done0), .ovf(ovf0)
    );

    // Slice model with M register (OPMODE 09: P <= P + A*B)
    logic signed [17:0] ra1 = 18'sd0, rb1 = 18'sd0;
    logic signed [35:0] rm1 = 36'sd0;
    logic signed [47:0] rp1 = 48'sd0;
    int jcep1 = 0;
    always @(posedge clk) begin
        if (cea1) ra1 <= da1;
        if (ceb1) rb1 <= db1;
        if (cem1) rm1 <= ra1 * rb1;
        if (rstp1) begin
            rp1 <= 48'sd0;
            jcep1 <= 0;
        end else if (cep1) begin
            rp1 <= rp1 + {{12{rm1[35]}}, rm1};
            jcep1 <= jcep1 + 1;
        end
    end
    assign p1 = rp1;
    assign carry1 = carry_en & cep1 & (jcep1 == 1);

    // Slice model without M register
    logic signed [17:0] ra0 = 18'sd0, rb0 = 18'sd0;
    logic signed [35:0] m0;
    logic signed [47:0] rp0 = 48'sd0;
    assign m0 = ra0 * rb0;
    always @(posedge clk) begin
        if (cea0) ra0 <= da0;
        if (ceb0) rb0 <= db0;
        if (rstp0) rp0 <= 48'sd0;
        else if (cep0) rp0 <= rp0 + {{12{m0[35]}}, m0};
    end
    assign p0 = rp0;
    assign carry0 = 1'b0;

    logic w_ready, w_done, w_ovf, w_rstp, w_cea, w_cem, w_cep;
    logic [47:0] w_result;
    assign w_ready  = sel ? ready0 : ready1;
    assign w_done   = sel ? done0  : done1;
    assign w_ovf    = sel ? ovf0   : ovf1;
    assign w_rstp   = sel ? rstp0  : rstp1;
    assign w_cea    = sel ? cea0   : cea1;
    assign w_cem    = sel ? cem0   : cem1;
    assign w_cep    = sel ? cep0   : cep1;
    assign w_result = sel ? res0   : res1;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (w_cea)  tot_cea  <= tot_cea + 1;
        if (w_cem)  tot_cem  <= tot_cem + 1;
        if (w_cep)  tot_cep  <= tot_cep + 1;
        if (w_rstp) tot_rstp <= tot_rstp + 1;
    end

    // Drives one job on the selected instance and reports what was observed.
    task automatic run_job(input int n, input int gap, output bit ok, output logic [47:0] g_res,
                           output logic g_ovf, output int lat, output int ncea, output int ncem,
                           output int ncep, output int nrstp, output logic rstp_clr,
                           output logic rdy_drain);
        longint sum = 0;
        logic   e_ovf;
        int s_cea, s_cem, s_cep, s_rstp, last, g;
        for (int i = 0; i < n; i++) sum += longint'(pa[i]) * longint'(pb[i]);
`ifdef DSP48A1_SEQ_OVF_EN
        e_ovf = carry_en && !sel && (n >= 2);
`else
        e_ovf = 1'b0;
`endif
        q_res.push_back(sum[47:0]);
        q_ovf.push_back(e_ovf);
        s_cea = tot_cea; s_cem = tot_cem; s_cep = tot_cep; s_rstp = tot_rstp;
        @(negedge clk);
        t_start = 1'b1;
        t_len   = n[7:0];
        @(negedge clk);
        t_start   = 1'b0;
        last      = cyc_n;
        rstp_clr  = w_rstp;
        rdy_drain = 1'b0;
        for (int i = 0; i < n; i++) begin
            t_a = pa[i][17:0];
            t_b = pb[i][17:0];
            t_valid = 1'b1;
            g = 0;
            while (!w_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            @(negedge clk);
            last      = cyc_n;
            rdy_drain = w_ready;
            t_valid   = 1'b0;
            if (i < n - 1) repeat (gap) @(negedge clk);
        end
        g = 0;
        while (!w_done && g < 40) begin
            @(negedge clk);
            g++;
        end
        ok    = (w_done === 1'b1);
        g_res = w_result;
        g_ovf = w_ovf;
        lat   = cyc_n - last;
        ncea  = tot_cea - s_cea;
        ncem  = tot_cem - s_cem;
        ncep  = tot_cep - s_cep;
        nrstp = tot_rstp - s_rstp;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy1, ready1, cea1, ceb1, cem1, cep1, rstp1, done1, ovf1} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_ctl1: got %b want 000000000",
                     {busy1, ready1, cea1, ceb1, cem1, cep1, rstp1, done1, ovf1});
        end
        n_cmp++;
        if ({res1, op1} !== {48'd0, 8'h09}) begin
            n_err++;
            $display("FAIL reset_res1: got result=%0h opmode=%0h want 0/09", res1, op1);
        end
        n_cmp++;
        if ({busy0, ready0, cea0, ceb0, cem0, cep0, rstp0, done0, ovf0} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_ctl0: got %b want 000000000",
                     {busy0, ready0, cea0, ceb0, cem0, cep0, rstp0, done0, ovf0});
        end
        n_cmp++;
        if ({res0, op0} !== {48'd0, 8'h09}) begin
            n_err++;
            $display("FAIL reset_res0: got result=%0h opmode=%0h want 0/09", res0, op0);
        end
        rst = 1'b0;
    endtask

    task automatic test_stall();
        bit ok; logic [47:0] r, e; logic o, eo, rc, rd; int lat, na, nm, np, nr;
        sel = 1'b0;
        pa[0] = 2;  pb[0] = 3;
        pa[1] = 4;  pb[1] = 5;
        pa[2] = -1; pb[2] = 7;
        run_job(3, 0, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL stall_done: got %0b want 1", ok); end
        n_cmp++; if (r !== e) begin n_err++; $display("FAIL stall_result: got %0d want %0d", $signed(r), $signed(e)); end
        n_cmp++; if (o !== eo) begin n_err++; $display("FAIL stall_ovf: got %0b want %0b", o, eo); end
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL stall_latency: got %0d want 3", lat); end
        n_cmp++; if (np != 3) begin n_err++; $display("FAIL stall_cep_count: got %0d want 3", np); end
        n_cmp++; if (na != 3) begin n_err++; $display("FAIL stall_cea_count: got %0d want 3", na); end
        n_cmp++; if (nr != 1 || rc !== 1'b1) begin n_err++; $display("FAIL stall_rstp: got count=%0d clear=%0b want 1/1", nr, rc); end
    endtask

    task automatic test_zero_len();
        bit ok; logic [47:0] r, e; logic o, eo, rc, rd; int lat, na, nm, np, nr;
        sel = 1'b0;
        run_job(0, 0, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (ok !== 1'b1 || lat != 0) begin n_err++; $display("FAIL zero_done_next: got done=%0b lat=%0d want 1/0", ok, lat); end
        n_cmp++; if (r !== e) begin n_err++; $display("FAIL zero_result: got %0d want %0d", $signed(r), $signed(e)); end
        n_cmp++; if (o !== eo) begin n_err++; $display("FAIL zero_ovf: got %0b want %0b", o, eo); end
        n_cmp++; if (na + nm + np != 0) begin n_err++; $display("FAIL zero_ce_pulses: got %0d want 0", na + nm + np); end
        n_cmp++; if (nr != 0) begin n_err++; $display("FAIL zero_rstp: got %0d want 0", nr); end
    endtask

    task automatic test_bubbles();
        bit ok; logic [47:0] r, e; logic o, eo, rc, rd; int lat, na, nm, np, nr;
        sel = 1'b0;
        pa[0] = 2;  pb[0] = 3;
        pa[1] = 4;  pb[1] = 5;
        pa[2] = -1; pb[2] = 7;
        run_job(3, 2, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL bubble_done: got %0b want 1", ok); end
        n_cmp++; if (r !== e) begin n_err++; $display("FAIL bubble_result: got %0d want %0d", $signed(r), $signed(e)); end
        n_cmp++; if (np != 3) begin n_err++; $display("FAIL bubble_cep_count: got %0d want 3", np); end
        n_cmp++; if (rd !== 1'b0) begin n_err++; $display("FAIL bubble_ready_drain: got %0b want 0", rd); end
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL bubble_latency: got %0d want 3", lat); end
    endtask

    task automatic test_back_to_back();
        bit ok; logic [47:0] r, e; logic o, eo, rc, rd; int lat, na, nm, np, nr;
        sel = 1'b1;
        pa[0] = 100; pb[0] = 100;
        pa[1] = -50; pb[1] = 2;
        run_job(2, 0, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b1_done: got %0b want 1", ok); end
        n_cmp++; if (r !== e) begin n_err++; $display("FAIL b2b1_result: got %0d want %0d", $signed(r), $signed(e)); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL b2b1_latency: got %0d want 2", lat); end
        n_cmp++; if (nm != 0) begin n_err++; $display("FAIL b2b1_cem: got %0d want 0", nm); end
        n_cmp++; if (np != 2) begin n_err++; $display("FAIL b2b1_cep_count: got %0d want 2", np); end
        pa[0] = 3; pb[0] = -4;
        run_job(1, 0, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (rc !== 1'b1) begin n_err++; $display("FAIL b2b2_rstp_clear: got %0b want 1", rc); end
        n_cmp++; if (ok !== 1'b1 || r !== e) begin n_err++; $display("FAIL b2b2_result: got done=%0b %0d want 1/%0d", ok, $signed(r), $signed(e)); end
        n_cmp++; if (o !== eo) begin n_err++; $display("FAIL b2b2_ovf: got %0b want %0b", o, eo); end
        n_cmp++; if (nm != 0) begin n_err++; $display("FAIL b2b2_cem: got %0d want 0", nm); end
    endtask

    task automatic test_reset_mid_feed();
        bit ok; logic [47:0] r, e; logic o, eo, rc, rd; int lat, na, nm, np, nr, g;
        sel = 1'b0;
        @(negedge clk);
        t_start = 1'b1;
        t_len   = 8'd4;
        @(negedge clk);
        t_start = 1'b0;
        t_a = 18'd5; t_b = 18'd5; t_valid = 1'b1;
        g = 0;
        while (!ready1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        t_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy1, ready1, cea1, ceb1, cem1, cep1, rstp1, done1, ovf1} !== 9'b0) begin
            n_err++;
            $display("FAIL midrst_ctl: got %b want 000000000",
                     {busy1, ready1, cea1, ceb1, cem1, cep1, rstp1, done1, ovf1});
        end
        n_cmp++;
        if (res1 !== 48'd0) begin n_err++; $display("FAIL midrst_result: got %0h want 0", res1); end
        rst = 1'b0;
        pa[0] = 7; pb[0] = 6;
        run_job(1, 0, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (ok !== 1'b1 || r !== e) begin n_err++; $display("FAIL midrst_job: got done=%0b %0d want 1/%0d", ok, $signed(r), $signed(e)); end
        n_cmp++; if (o !== eo) begin n_err++; $display("FAIL midrst_ovf: got %0b want %0b", o, eo); end
    endtask

    task automatic test_ovf();
        bit ok; logic [47:0] r, e; logic o, eo, rc, rd; int lat, na, nm, np, nr;
        sel = 1'b0;
        carry_en = 1'b1;
        pa[0] = 2;  pb[0] = 3;
        pa[1] = 4;  pb[1] = 5;
        pa[2] = -1; pb[2] = 7;
        run_job(3, 0, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (ok !== 1'b1 || o !== eo) begin n_err++; $display("FAIL ovf_set: got done=%0b ovf=%0b want 1/%0b", ok, o, eo); end
        n_cmp++; if (r !== e) begin n_err++; $display("FAIL ovf_result: got %0d want %0d", $signed(r), $signed(e)); end
        carry_en = 1'b0;
        pa[0] = 7; pb[0] = 6;
        run_job(1, 0, ok, r, o, lat, na, nm, np, nr, rc, rd);
        e = q_res.pop_front(); eo = q_ovf.pop_front();
        n_cmp++; if (ok !== 1'b1 || o !== eo) begin n_err++; $display("FAIL ovf_clean: got done=%0b ovf=%0b want 1/%0b", ok, o, eo); end
        n_cmp++; if (r !== e) begin n_err++; $display("FAIL ovf_clean_result: got %0d want %0d", $signed(r), $signed(e)); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_stall();
        test_zero_len();
        test_bubbles();
        test_back_to_back();
        test_reset_mid_feed();
        test_ovf();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dsp48a1_mac_sequencer.md
# dsp48a1_mac_sequencer

Control sequencer that runs a length-N multiply-accumulate job on one DSP48A1 slice instance. Accepts a start command, streams operand pairs into the slice over a valid/ready handshake, and drives OPMODE, clock enables and the P reset. Tracks the slice pipeline so input stalls never cause a spurious accumulate. Captures the final P value and pulses done. Sits between the host or control FSM and the slice datapath.

## Interface
- `LEN_W`, default 8: width of the job length field.
- `MREG`, default 1: slice M register present (1) or combinational (0). Must match the slice configuration.
- `clk` in 1: clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request; sampled only in IDLE.
- `len` in LEN_W: number of operand pairs; sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `s_valid` in 1: operand pair valid.
- `s_ready` out 1: sequencer accepts the pair.
- `s_a` in 18: A operand.
- `s_b` in 18: B operand.
- `dsp_a` out 18: wire from `s_a` to slice A.
- `dsp_b` out 18: wire from `s_b` to slice B.
- `dsp_opmode` out 8: slice OPMODE.
- `dsp_cea` out 1: slice A-register clock enable.
- `dsp_ceb` out 1: slice B-register clock enable.
- `dsp_cem` out 1: slice M clock enable.
- `dsp_cep` out 1: slice P clock enable.
- `dsp_rstp` out 1: slice P reset.
- `dsp_p` in 48: slice P output.
- `dsp_carryout` in 1: slice CARRYOUT.
- `result` out 48: final accumulated P, held until the next DONE.
- `done` out 1: one-cycle completion pulse.
- `ovf` out 1: overflow flag for the completed job. See Configuration.

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, DONE.
- Opcode: `dsp_opmode` is constant 8'h09 (X=M, Z=P, post-adder add, no pre-adder).
- Outputs are decoded from registered state and counters. `dsp_a` and `dsp_b` are pure wires.

State transitions:
- IDLE
  - `start` && `len`!=0 -> CLEAR. Latch `len` into the remaining counter `cnt`.
  - `start` && `len`==0 -> DONE. Result becomes 0.
- CLEAR (1 cycle): `dsp_rstp`=1 -> FEED.
- FEED
  - `s_ready`=1.
  - accept = `s_valid` && `s_ready`.
  - On accept: `dsp_cea` = `dsp_ceb` = 1 and `cnt` decrements.
  - Accept with `cnt`==1 -> DRAIN.
- DRAIN
  - `s_ready`=0.
  - Stay until the pipeline valid vector is zero, then -> DONE.
- DONE (1 cycle)
  - `done`=1.
  - `result` <= `dsp_p`, or 0 for a zero-length job.
  - -> IDLE.

Pipeline tracking:
- Valid shift vector `v` of width 1+MREG. `v[0]` <= accept; higher bits shift each cycle.
- MREG=1: `dsp_cem`=`v[0]`, `dsp_cep`=`v[1]`.
- MREG=0: `dsp_cem`=0, `dsp_cep`=`v[0]`.
- `v` keeps shifting in every state. Bubbles produce no CEP, so P accumulates exactly `len` products.

Boundary behaviour:
- `start` outside IDLE is ignored.
- `s_valid` outside FEED is not accepted.
- An accept in the same cycle as FEED->DRAIN still enters `v` normally.
- Reset mid-job: the job is abandoned and `v` is cleared. The next job's CLEAR clears stale P.

Reset values (after a `rst` cycle):
- State IDLE, `cnt`=0, `v`=0.
- `busy`=0, `s_ready`=0, all CE=0, `dsp_rstp`=0, `done`=0, `result`=0, `ovf`=0.
- `dsp_opmode`=8'h09.

## Timing
- Start sampled at edge t: CLEAR in cycle t+1, FEED from t+2.
- Accept at edge k: A/B registers load at k. M loads at k+1 (MREG=1). P updates at k+1+MREG.
- Latency from the last accept to `done`:
  - MREG=1: `done` high in the cycle beginning at edge k+3.
  - MREG=0: `done` high in the cycle beginning at edge k+2.
- Zero-length job: `done` is high the cycle after `start`.
- Back-to-back jobs: `start` is accepted in the IDLE cycle immediately following DONE.

## Configuration
- Macro: `DSP48A1_SEQ_OVF_EN`.
- When defined:
  - A sticky flag is set whenever `dsp_carryout`=1 in a cycle where `dsp_cep`=1.
  - The flag clears in CLEAR and on `rst`.
  - `ovf` is the flag value, registered and updated together with `result` in DONE.
- When undefined: `ovf` is tied 0 and `dsp_carryout` is unused.

## Test plan
- Stall tracking: MREG=1, `len`=3, pairs (2,3),(4,5),(−1,7) with `s_valid` continuous -> `result`=19. `done` 3 cycles after the last accept. Exactly 3 CEP pulses.
- Bubbles: same job with `s_valid` low for 2 cycles between each pair -> `result`=19, still 3 CEP pulses, `s_ready` low in DRAIN.
- Zero length: `len`=0 -> `done` the next cycle, `result`=0, no CE pulses, no `dsp_rstp`.
- MREG=0 and back-to-back: `len`=2, (100,100),(−50,2). Then `start` in the IDLE cycle after DONE for a second job -> first `result`=9900 and `dsp_cem` never asserted. Second job begins with a `dsp_rstp` pulse.
- Reset mid-FEED: `rst` after 1 of 4 pairs -> all outputs at reset values next cycle. A new `len`=1 (7,6) job gives `result`=42.
- Overflow, `DSP48A1_SEQ_OVF_EN` defined: model `dsp_carryout`=1 on the 2nd CEP -> `ovf`=1 with `done`. The next clean job gives `ovf`=0.
